note_detector: RTL
==================

// Module: note_detector
// PURPOSE
// Receive-side counterpart of the song tone generator. Measures the period of an incoming
// square-wave audio line and classifies it as one of the eight song notes A..B_LOW, or as
// silence. Drives the same four 7-seg digit codes the generator uses, so the display shows
// what is actually heard. Sits between the audio pin/loopback and the seven-segment mux.
// PARAMETERS
// A_HIGH_NOTE  227_273    full period in CLK cycles, note 0 (440 Hz @ 100 MHz)
// E_HIGH_NOTE  303_373    note 1;  B_NOTE 404_954 note 2;  G_NOTE 510_210 note 3
// D_NOTE       681_049    note 4;  A_NOTE 909_091 note 5;  E_LOW_NOTE 1_213_490 note 6
// B_LOW_NOTE   1_619_820  note 7
// TOL_SHIFT    4          match window = +/- (NOTE >> TOL_SHIFT) cycles (6.25%)
// CONFIRM      3          consecutive equal classifications needed to change output
// TIMEOUT      3_300_000  cycles with no rising edge -> silence
// PORTS
// CLK        in   1  system clock
// RST_N      in   1  asynchronous active-low reset
// audioIn    in   1  square-wave audio, asynchronous to CLK
// noteIdx    out  4  detected note 0..7; 8 = silence/unknown
// noteValid  out  1  1 while noteIdx is in 0..7
// newNote    out  1  single-cycle pulse whenever noteIdx changes value
// detOnes, detTens, detHund, detThou  out  4 each  7-seg digit codes for the current noteIdx
// BEHAVIOUR
// Reset (async, RST_N=0): noteIdx=8, noteValid=0, newNote=0, digits 7/7/7/7,
//   state SILENT, counter=0, candidate=8, match count=0. Takes effect mid-period too.
// Input path: 2-FF synchronizer, then rising-edge detect -> edge pulse 3 CLKs after pin rise.
// Period counter: 24-bit, cleared on edge pulse, +1 otherwise, saturates at 2^24-1.
//   Measured P = CLK cycles between successive edge pulses.
// FSM:
//   SILENT: counter idle. Edge -> ARMED (no classification on first edge).
//   ARMED:  edge -> classify P, -> TRACK. Counter reaches TIMEOUT -> SILENT.
//   TRACK:  edge -> classify P, stay. Counter reaches TIMEOUT -> SILENT.
//     Timeout also forces noteIdx=8 the next cycle, clears candidate and match count,
//     and pulses newNote if noteIdx was not already 8.
// Classify: class k if |P - NOTE_k| <= NOTE_k >> TOL_SHIFT, else class 8.
//   Windows are disjoint. Check k=0..7 in order; first hit wins.
// Confirm: if class == candidate, match count +1 (saturates at CONFIRM);
//   else candidate=class, count=1.
//   When count reaches CONFIRM and candidate != noteIdx, load noteIdx=candidate on the
//   cycle after the classifying edge, and pulse newNote for that same cycle.
// Latency: output updates 1 CLK after the edge pulse that completes confirmation.
// Digit codes per noteIdx (Thou,Hund,Tens,Ones):
//   0: 0,7,5,8   1: 1,7,5,8   2: 2,7,7,7   3: 3,7,7,7   4: 4,7,7,7   5: 0,7,7,7
//   6: 1,7,6,9   7: 2,7,6,9   8: 7,7,7,7
//   Digits are registered with noteIdx, with no extra delay.
// noteValid = (noteIdx != 8), registered alongside noteIdx.
// Edge pulse on the same cycle the counter hits TIMEOUT: the edge wins.
//   Classify P, with no timeout.
// All arithmetic is unsigned 24-bit. The difference is computed as max-min, so there is no
//   sign handling.
// TESTING
// 1) Reset, then 4 rising edges at period 227_273 -> noteIdx=0, digits 0/7/5/8, noteValid=1,
//    newNote pulses 1 CLK after the 4th edge pulse. Nothing changes before that.
// 2) After (1), switch to period 1_619_820 -> the first 2 new periods keep noteIdx=0;
//    the 3rd sets noteIdx=7, digits 2/7/6/9, one newNote pulse.
// 3) Periods alternating 227_273 / 303_373 -> the match count never reaches 3,
//    so noteIdx holds its prior value and newNote stays 0.
// 4) Hold audioIn low 3_300_000 CLKs after a locked note -> noteIdx=8, noteValid=0,
//    digits 7/7/7/7, one newNote pulse.
// 5) Period 260_000 (between notes 0 and 1) x3 -> class 8 confirmed; noteIdx=8.
//    Period 240_000 (+5.6%) x3 -> noteIdx=0.
// 6) Pull RST_N low mid-period while locked on note 4 -> outputs go silent immediately,
//    asynchronously. After release, the first edge only arms the FSM.

Source files
------------

// File: rtl/note_detector.sv
// rtl/note_detector.sv - measures the period of a square-wave audio input and classifies it as one of eight song notes or silence
module note_detector #(
    parameter int unsigned A_HIGH_NOTE = 227_273,
    parameter int unsigned E_HIGH_NOTE = 303_373,
    parameter int unsigned B_NOTE      = 404_954,
    parameter int unsigned G_NOTE      = 510_210,
    parameter int unsigned D_NOTE      = 681_049,
    parameter int unsigned A_NOTE      = 909_091,
    parameter int unsigned E_LOW_NOTE  = 1_213_490,
    parameter int unsigned B_LOW_NOTE  = 1_619_820,
    parameter int unsigned TOL_SHIFT   = 4,
    parameter int unsigned CONFIRM     = 3,
    parameter int unsigned TIMEOUT     = 3_300_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       audioIn,
    output logic [3:0] noteIdx,
    output logic       noteValid,
    output logic       newNote,
    output logic [3:0] detOnes,
    output logic [3:0] detTens,
    output logic [3:0] detHund,
    output logic [3:0] detThou
);

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        ARMED  = 2'd1,
        TRACK  = 2'd2
    } state_t;

    localparam logic [23:0] CNT_MAX   = 24'hFF_FFFF;
    localparam logic [23:0] TIMEOUT_C = 24'(TIMEOUT);
    localparam logic [3:0]  SIL_IDX   = 4'd8;
    localparam logic [3:0]  CONFIRM_C = 4'(CONFIRM);

    function automatic logic [23:0] note_period(input int k);
        case (k)
            0:       note_period = 24'(A_HIGH_NOTE);
            1:       note_period = 24'(E_HIGH_NOTE);
            2:       note_period = 24'(B_NOTE);
            3:       note_period = 24'(G_NOTE);
            4:       note_period = 24'(D_NOTE);
            5:       note_period = 24'(A_NOTE);
            6:       note_period = 24'(E_LOW_NOTE);
            default: note_period = 24'(B_LOW_NOTE);
        endcase
    endfunction

    // Packed as {thou, hund, tens, ones}
    function automatic logic [15:0] digits_of(input logic [3:0] idx);
        case (idx)
            4'd0:    digits_of = 16'h0758;
            4'd1:    digits_of = 16'h1758;
            4'd2:    digits_of = 16'h2777;
            4'd3:    digits_of = 16'h3777;
            4'd4:    digits_of = 16'h4777;
            4'd5:    digits_of = 16'h0777;
            4'd6:    digits_of = 16'h1769;
            4'd7:    digits_of = 16'h2769;
            default: digits_of = 16'h7777;
        endcase
    endfunction

    logic        sync1, sync2, sync3, edge_q;
    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  mcnt_q, mcnt_d;
    logic [3:0]  note_d;
    logic        new_d;
    logic [23:0] period_meas;
    logic [23:0] np, diff;
    logic [3:0]  cls;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync3  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync1  <= audioIn;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_q <= sync2 & ~sync3;
        end
    end

    // The counter holds P-1 on the edge that closes a period of P cycles
    assign period_meas = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 24'd1;

    // Scan downwards so the lowest matching note index wins
    always_comb begin
        cls  = SIL_IDX;
        np   = '0;
        diff = '0;
        for (int k = 7; k >= 0; k--) begin
            np   = note_period(k);
            diff = (period_meas > np) ? (period_meas - np) : (np - period_meas);
            if (diff <= (np >> TOL_SHIFT)) begin
                cls = 4'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        mcnt_d  = mcnt_q;
        note_d  = noteIdx;
        new_d   = 1'b0;
        case (state_q)
            SILENT: begin
                cnt_d = '0;
                if (edge_q) begin
                    state_d = ARMED;
                end
            end
            ARMED, TRACK: begin
                if (edge_q) begin
                    state_d = TRACK;
                    cnt_d   = '0;
                    if (cls == cand_q) begin
                        mcnt_d = (mcnt_q >= CONFIRM_C) ? CONFIRM_C : mcnt_q + 4'd1;
                    end else begin
                        cand_d = cls;
                        mcnt_d = 4'd1;
                    end
                    if (mcnt_d >= CONFIRM_C && cand_d != noteIdx) begin
                        note_d = cand_d;
                        new_d  = 1'b1;
                    end
                end else if (cnt_q >= TIMEOUT_C) begin
                    state_d = SILENT;
                    cnt_d   = '0;
                    cand_d  = SIL_IDX;
                    mcnt_d  = '0;
                    note_d  = SIL_IDX;
                    new_d   = (noteIdx != SIL_IDX);
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = SILENT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= SILENT;
            cnt_q     <= '0;
            cand_q    <= SIL_IDX;
            mcnt_q    <= '0;
            noteIdx   <= SIL_IDX;
            noteValid <= 1'b0;
            newNote   <= 1'b0;
            {detThou, detHund, detTens, detOnes} <= 16'h7777;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            mcnt_q    <= mcnt_d;
            noteIdx   <= note_d;
            noteValid <= (note_d != SIL_IDX);
            newNote   <= new_d;
            {detThou, detHund, detTens, detOnes} <= digits_of(note_d);
        end
    end

endmodule
